// File: rtl/pe_credit_node.sv
// pe_credit_node: NoC processing element with a credit-controlled injection path and an always-ready sink.
// Latency: a core flit reaches dataout/out_valid one edge after it is written; co pulses one edge after each accepted flit.
// Backpressure: core_ready drops when the injection FIFO is full; the router is throttled by credits; the sink never stalls.

// pe_fifo: generic single-clock FIFO with an occupancy counter and a registered head.
// Latency: a pushed word is readable at the head the cycle after the push edge.
// Backpressure: push is dropped while full and pop is ignored while empty, so the caller gates with full/empty.
module pe_fifo #(
    parameter int W     = 20,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         full,
    output logic         empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          wr_en;
    logic          rd_en;

    // Full/empty come straight from the occupancy counter so they only reflect pre-edge state.
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign wr_en    = push && !full;
    assign rd_en    = pop && !empty;
    assign head_dat = mem[rd_ptr];

    // Storage array; cleared on reset so stale flits never reappear after a mid-packet reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Occupancy 0..DEPTH; a simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else begin
            unique case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// pe_credit_node: top level tying the injection FIFO, credit counter and receive statistics together.
// Latency: one edge from FIFO write to dataout; one edge from in_valid to co/read/statistics.
// Backpressure: core_ready = !full; sends stop at zero credits; incoming flits are always accepted.
module pe_credit_node #(
    parameter int FLIT_W   = 20,
    parameter int CREDITS  = 7,
    parameter int OQ_DEPTH = 4,
    parameter int CNT_W    = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [FLIT_W-1:0]            core_data,
    input  logic                         core_valid,
    output logic                         core_ready,
    output logic [FLIT_W-1:0]            dataout,
    output logic                         out_valid,
    input  logic                         ci,
    input  logic [FLIT_W-1:0]            datain,
    input  logic                         in_valid,
    output logic                         co,
    output logic [CNT_W-1:0]             read,
    output logic [CNT_W-1:0]             rx_flits,
    output logic [CNT_W-1:0]             rx_pkts,
    output logic [$clog2(CREDITS+1)-1:0] credit_cnt,
    output logic                         err
);

    localparam int CRW = $clog2(CREDITS + 1);

    localparam logic [1:0] TYPE_INVALID = 2'b00;
    localparam logic [1:0] TYPE_TAIL    = 2'b11;

    logic              fifo_full;
    logic              fifo_empty;
    logic [FLIT_W-1:0] fifo_head;
    logic              send;
    logic [1:0]        rx_type;
    logic              credit_overflow;
    logic              rx_invalid;

    // A flit leaves only when there is something queued and the router has room for it.
    assign send       = !fifo_empty && (credit_cnt != '0);
    assign core_ready = !fifo_full;
    assign rx_type    = datain[FLIT_W-1 -: 2];

    // A returned credit with nothing in flight means the router and this node disagree on buffer state.
    assign credit_overflow = ci && !send && (credit_cnt == CRW'(CREDITS));
    assign rx_invalid      = in_valid && (rx_type == TYPE_INVALID);

    pe_fifo #(
        .W     (FLIT_W),
        .DEPTH (OQ_DEPTH)
    ) u_oq (
        .clk      (clk),
        .rst      (rst),
        .push     (core_valid),
        .push_dat (core_data),
        .pop      (send),
        .head_dat (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Registered send stage; dataout holds its last flit so out_valid alone qualifies it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dataout   <= '0;
            out_valid <= 1'b0;
        end else if (send) begin
            dataout   <= fifo_head;
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end

    // Credit counter: send consumes, ci returns, both cancel, saturating at the router depth.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credit_cnt <= CRW'(CREDITS);
        end else begin
            unique case ({send, ci})
                2'b10: credit_cnt <= credit_cnt - CRW'(1);
                2'b01: begin
                    if (credit_cnt != CRW'(CREDITS)) begin
                        credit_cnt <= credit_cnt + CRW'(1);
                    end
                end
                default: credit_cnt <= credit_cnt;
            endcase
        end
    end

    // Receive side: every in_valid flit is taken, counted and credited back the next cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            co       <= 1'b0;
            read     <= '0;
            rx_flits <= '0;
            rx_pkts  <= '0;
        end else begin
            co <= in_valid;
            if (in_valid) begin
                read     <= datain[CNT_W-1:0];
                rx_flits <= rx_flits + CNT_W'(1);
                if (rx_type == TYPE_TAIL) begin
                    rx_pkts <= rx_pkts + CNT_W'(1);
                end
            end
        end
    end

    // Sticky error: credit overflow or an invalid-type flit; only reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (credit_overflow || rx_invalid) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pe_credit_node.sv
// Bench for pe_credit_node: directed scenarios plus randomized traffic against a queue-based reference model.
// Every cycle the model's view of all outputs is compared with the design.
// The model works on whole-transaction rules: a flit queue, an integer credit balance and integer counters.
module tb_pe_credit_node;

    localparam int FW  = 20;
    localparam int CR  = 7;
    localparam int OQ  = 4;
    localparam int CW  = 16;
    localparam int CRW = $clog2(CR + 1);

    logic          clk;
    logic          rst;
    logic [FW-1:0] core_data;
    logic          core_valid;
    logic          core_ready;
    logic [FW-1:0] dataout;
    logic          out_valid;
    logic          ci;
    logic [FW-1:0] datain;
    logic          in_valid;
    logic          co;
    logic [CW-1:0] read;
    logic [CW-1:0] rx_flits;
    logic [CW-1:0] rx_pkts;
    logic [CRW-1:0] credit_cnt;
    logic          err;

    pe_credit_node #(
        .FLIT_W   (FW),
        .CREDITS  (CR),
        .OQ_DEPTH (OQ),
        .CNT_W    (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .core_data  (core_data),
        .core_valid (core_valid),
        .core_ready (core_ready),
        .dataout    (dataout),
        .out_valid  (out_valid),
        .ci         (ci),
        .datain     (datain),
        .in_valid   (in_valid),
        .co         (co),
        .read       (read),
        .rx_flits   (rx_flits),
        .rx_pkts    (rx_pkts),
        .credit_cnt (credit_cnt),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_q[$];
    int m_cred;
    bit m_err;
    int m_dout;
    bit m_ov;
    bit m_co;
    int m_read;
    int m_flits;
    int m_pkts;
    bit acc;
    int obs_sent[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_cred  = CR;
        m_err   = 1'b0;
        m_dout  = 0;
        m_ov    = 1'b0;
        m_co    = 1'b0;
        m_read  = 0;
        m_flits = 0;
        m_pkts  = 0;
    endtask

    task automatic check_all();
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
        chk("dataout", {12'd0, dataout}, m_dout);
        chk("credit_cnt", {29'd0, credit_cnt}, m_cred);
        chk("co", {31'd0, co}, {31'd0, m_co});
        chk("read", {16'd0, read}, m_read);
        chk("rx_flits", {16'd0, rx_flits}, m_flits);
        chk("rx_pkts", {16'd0, rx_pkts}, m_pkts);
        chk("err", {31'd0, err}, {31'd0, m_err});
        chk("core_ready", {31'd0, core_ready}, {31'd0, (m_q.size() < OQ)});
    endtask

    // One clock: drive inputs, advance the model on the pre-edge state, compare after the edge.
    task automatic cycle(input bit cv, input logic [FW-1:0] cd, input bit ci_i,
                         input bit iv, input logic [FW-1:0] di);
        bit snd;
        bit psh;
        core_valid = cv;
        core_data  = cd;
        ci         = ci_i;
        in_valid   = iv;
        datain     = di;
        chk("core_ready_pre", {31'd0, core_ready}, {31'd0, (m_q.size() < OQ)});
        snd = (m_q.size() > 0) && (m_cred > 0);
        psh = cv && (m_q.size() < OQ);
        acc = psh;
        @(posedge clk);
        if (snd) begin
            m_dout = m_q.pop_front();
            m_ov   = 1'b1;
        end else begin
            m_ov = 1'b0;
        end
        if (psh) m_q.push_back(int'(cd));
        if (snd && !ci_i) begin
            m_cred--;
        end else if (ci_i && !snd) begin
            if (m_cred == CR) m_err = 1'b1;
            else m_cred++;
        end
        m_co = iv;
        if (iv) begin
            m_read  = int'(di) & 32'hFFFF;
            m_flits = (m_flits + 1) & 32'hFFFF;
            if (di[FW-1:FW-2] == 2'b11) m_pkts = (m_pkts + 1) & 32'hFFFF;
            if (di[FW-1:FW-2] == 2'b00) m_err = 1'b1;
        end
        #1;
        check_all();
        if (out_valid === 1'b1) obs_sent.push_back(int'(dataout));
        core_valid = 1'b0;
        ci         = 1'b0;
        in_valid   = 1'b0;
    endtask

    task automatic idle();
        cycle(1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    // Present a flit until the FIFO takes it.
    task automatic push_flit(input logic [FW-1:0] f);
        int n;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 50) begin
            cycle(1'b1, f, 1'b0, 1'b0, '0);
            n++;
        end
        if (!acc) chk("push_timeout", 32'd0, 32'd1);
    endtask

    // Return credits until the queue is drained and the balance is full again.
    task automatic restore_credits();
        int n;
        n = 0;
        while ((m_q.size() != 0 || m_cred != CR) && n < 60) begin
            cycle(1'b0, '0, (m_cred < CR), 1'b0, '0);
            n++;
        end
        if (n >= 60) chk("restore_timeout", 32'd0, 32'd1);
    endtask

    // Asynchronous reset asserted mid-cycle, checked before the next edge.
    task automatic do_reset();
        core_valid = 1'b0;
        ci         = 1'b0;
        in_valid   = 1'b0;
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_all();
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b0;
        core_valid = 1'b0;
        core_data  = '0;
        ci         = 1'b0;
        in_valid   = 1'b0;
        datain     = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_cred", {29'd0, credit_cnt}, 32'd7);
        chk("rst_ready", {31'd0, core_ready}, 32'd1);
        chk("rst_ov", {31'd0, out_valid}, 32'd0);
        chk("rst_co", {31'd0, co}, 32'd0);
        chk("rst_flits", {16'd0, rx_flits}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);

        // Credit exhaustion: 10 flits with no credit return
        obs_sent.delete();
        for (int k = 0; k < 10; k++) push_flit(20'h40001 + 20'(k));
        repeat (4) idle();
        chk("exh_sends", obs_sent.size(), 32'd7);
        for (int k = 0; k < obs_sent.size() && k < 7; k++) chk("exh_order", obs_sent[k], 32'h40001 + k);
        chk("exh_cred", {29'd0, credit_cnt}, 32'd0);
        obs_sent.delete();
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, '0, 1'b1, 1'b0, '0);
            idle();
        end
        chk("rel_sends", obs_sent.size(), 32'd3);
        for (int k = 0; k < obs_sent.size() && k < 3; k++) chk("rel_order", obs_sent[k], 32'h40008 + k);

        // FIFO full at zero credits
        for (int k = 0; k < 4; k++) push_flit(20'h45000 + 20'(k));
        chk("full_ready0", {31'd0, core_ready}, 32'd0);
        cycle(1'b1, 20'h4FFFF, 1'b0, 1'b0, '0);
        chk("full_reject_ready", {31'd0, core_ready}, 32'd0);
        cycle(1'b0, '0, 1'b1, 1'b0, '0);
        chk("full_after_ci", {31'd0, core_ready}, 32'd0);
        idle();
        chk("full_ready_back", {31'd0, core_ready}, 32'd1);
        chk("full_pop", {12'd0, dataout}, 32'h45000);
        restore_credits();
        chk("restored_cred", {29'd0, credit_cnt}, 32'd7);
        chk("no_err_yet", {31'd0, err}, 32'd0);

        // Simultaneous ci and send at 3 credits, then overflow at 7
        for (int k = 0; k < 4; k++) push_flit(20'h41000 + 20'(k));
        while (m_q.size() != 0) idle();
        idle();
        chk("sim_pre_cred", {29'd0, credit_cnt}, 32'd3);
        cycle(1'b1, 20'h42000, 1'b0, 1'b0, '0);
        cycle(1'b0, '0, 1'b1, 1'b0, '0);
        chk("sim_cred", {29'd0, credit_cnt}, 32'd3);
        chk("sim_ov", {31'd0, out_valid}, 32'd1);
        restore_credits();
        idle();
        cycle(1'b0, '0, 1'b1, 1'b0, '0);
        chk("ovf_cred", {29'd0, credit_cnt}, 32'd7);
        chk("ovf_err", {31'd0, err}, 32'd1);

        // 3-flit packet received
        do_reset();
        cycle(1'b0, '0, 1'b0, 1'b1, 20'h4ABCD);
        chk("rx_co1", {31'd0, co}, 32'd1);
        cycle(1'b0, '0, 1'b0, 1'b1, 20'h81234);
        chk("rx_co2", {31'd0, co}, 32'd1);
        cycle(1'b0, '0, 1'b0, 1'b1, 20'hC5678);
        chk("rx_co3", {31'd0, co}, 32'd1);
        chk("rx_flits3", {16'd0, rx_flits}, 32'd3);
        chk("rx_pkts1", {16'd0, rx_pkts}, 32'd1);
        chk("rx_read", {16'd0, read}, 32'h5678);
        idle();
        chk("rx_co_off", {31'd0, co}, 32'd0);
        chk("rx_err0", {31'd0, err}, 32'd0);

        // All-zero flit on both paths
        cycle(1'b1, 20'h00000, 1'b0, 1'b0, '0);
        idle();
        chk("zero_ov", {31'd0, out_valid}, 32'd1);
        chk("zero_dout", {12'd0, dataout}, 32'd0);
        cycle(1'b0, '0, 1'b0, 1'b1, 20'h00000);
        chk("zero_rx_err", {31'd0, err}, 32'd1);
        chk("zero_rx_co", {31'd0, co}, 32'd1);

        // Randomized traffic with one mid-run reset
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            logic [FW-1:0] cd;
            logic [FW-1:0] di;
            logic [1:0]    t;
            bit            cv;
            bit            ci_r;
            bit            iv;
            if (i == 700) do_reset();
            cd = FW'($urandom);
            t  = 2'($urandom_range(0, 3));
            if (t == 2'b00 && $urandom_range(0, 7) != 0) t = 2'b10;
            di = {t, 18'($urandom)};
            cv = ($urandom_range(0, 3) != 0);
            if (m_cred < CR) ci_r = ($urandom_range(0, 2) == 0);
            else ci_r = ($urandom_range(0, 40) == 0);
            iv = ($urandom_range(0, 1) == 1);
            cycle(cv, cd, ci_r, iv, di);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
